// File: rtl/fifo_wr_ptr_full.sv
// Write-domain pointer and full-flag controller for an asynchronous FIFO.
// Keeps the binary/Gray write pointers and derives full, almost-full and fill level.
module fifo_wr_ptr_full #(
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_inc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH:0]   w_ptr,
    output logic                  w_full,
    output logic                  w_almost_full,
    output logic [ADDR_WIDTH:0]   w_level
);

    localparam int AW = ADDR_WIDTH;
    localparam logic [AW:0] AF_THRESH = (AW+1)'(AF_LEVEL);

    logic [AW:0] wbin;
    logic [AW:0] wbin_next;
    logic [AW:0] gnext;
    logic [AW:0] rbin;
    logic [AW:0] level_next;
    logic        write_ok;
    logic        full_next;

    assign write_ok  = w_inc & ~w_full;
    assign w_en      = write_ok;
    assign w_addr    = wbin[AW-1:0];
    assign wbin_next = wbin + {{AW{1'b0}}, write_ok};
    assign gnext     = wbin_next ^ (wbin_next >> 1);

    // Full when the next write pointer sits exactly one lap ahead of the read pointer.
    assign full_next  = (gnext == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]});
    assign level_next = wbin_next - rbin;

    // NOTE: every bit gets a default before the loop so no latch can be inferred.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(wq2_rptr >> i);
        end
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin          <= '0;
            w_ptr         <= '0;
            w_full        <= 1'b0;
            w_almost_full <= 1'b0;
            w_level       <= '0;
        end else begin
            wbin          <= wbin_next;
            w_ptr         <= gnext;
            w_full        <= full_next;
            w_almost_full <= (level_next >= AF_THRESH);
            w_level       <= level_next;
        end
    end

endmodule
